// File: rtl/bet_ledger_pkg.sv
// bet_ledger_pkg
// Shared definitions for the wager/balance ledger of the baccarat round:
// ledger FSM state encoding, bet side codes, win-light codes and the width
// of the settlement credit arithmetic.
package bet_ledger_pkg;

    // Ledger FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_LOCKED = 3'd2,
        ST_SWAIT  = 3'd3,
        ST_SCALC  = 3'd4
    } state_t;

    // Bet side codes as presented on bet_side.
    localparam logic [1:0] SIDE_NONE   = 2'b00;
    localparam logic [1:0] SIDE_PLAYER = 2'b01;
    localparam logic [1:0] SIDE_DEALER = 2'b10;
    localparam logic [1:0] SIDE_TIE    = 2'b11;

    // Win lights packed as {player_win_light, dealer_win_light}.
    localparam logic [1:0] LIGHTS_PLAYER = 2'b10;
    localparam logic [1:0] LIGHTS_DEALER = 2'b01;
    localparam logic [1:0] LIGHTS_TIE    = 2'b11;

    // Settlement credit width; holds (15+1)*255 without overflow.
    localparam int unsigned CREDIT_W = 12;

endpackage

// File: rtl/bet_ledger_ctrl_payout_calc.sv
// payout_calc
// Purely combinational settlement credit: given the escrowed stake, the side
// it was placed on and the round's win lights, returns the total amount to
// credit back to the balance (stake included).
// Ports:
//   i_bet     in  8         escrowed stake
//   i_side    in  2         side the stake was placed on
//   i_lights  in  2         {player_win_light, dealer_win_light}
//   o_credit  out CREDIT_W  total credit (0 on a loss)
module payout_calc
    import bet_ledger_pkg::*;
#(
    parameter logic [3:0] TIE_MULT = 4'd8
) (
    input  logic [7:0]          i_bet,
    input  logic [1:0]          i_side,
    input  logic [1:0]          i_lights,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam logic [CREDIT_W-1:0] TIE_FACTOR = CREDIT_W'(TIE_MULT) + CREDIT_W'(1);

    logic [CREDIT_W-1:0] w_bet_ext;

    assign w_bet_ext = CREDIT_W'(i_bet);

    always_comb begin
        o_credit = '0;
        case (i_lights)
            LIGHTS_PLAYER: if (i_side == SIDE_PLAYER) o_credit = w_bet_ext << 1;
            LIGHTS_DEALER: if (i_side == SIDE_DEALER) o_credit = w_bet_ext << 1;
            LIGHTS_TIE: begin
                if (i_side == SIDE_TIE)
                    o_credit = TIE_FACTOR * w_bet_ext;
                else if (i_side != SIDE_NONE)
                    o_credit = w_bet_ext;   // push: stake refunded
            end
            default: o_credit = '0;
        endcase
    end

endmodule

// File: rtl/bet_ledger_ctrl.sv
// bet_ledger_ctrl
// Wager and balance sequencer for one baccarat round: accepts a single bet
// per round, holds the stake in escrow, settles it from the win lights and
// maintains the saturating 8-bit spendable balance.
// Ports:
//   slow_clock        in   1  clock, rising edge
//   reset             in   1  synchronous, active-high
//   bet_open          in   1  opens the bet window (honoured only in IDLE)
//   bet_valid         in   1  bet offer, qualifies bet_amount/bet_side
//   bet_amount        in   8  stake
//   bet_side          in   2  01 player, 10 dealer, 11 tie, 00 illegal
//   settle_req        in   1  settlement strobe; lights valid the next cycle
//   player_win_light  in   1  round result
//   dealer_win_light  in   1  round result (both high = tie)
//   balance           out  8  spendable balance, escrow excluded
//   bet_ack           out  1  1-cycle pulse, bet accepted
//   bet_reject        out  1  1-cycle pulse, bet refused
//   settle_done       out  1  1-cycle pulse, balance updated
//   busy              out  1  high while settling (SWAIT/SCALC)
//   broke             out  1  balance zero with nothing in escrow
module bet_ledger_ctrl
    import bet_ledger_pkg::*;
#(
    parameter logic [7:0] INIT_BALANCE = 8'd100,
    parameter logic [3:0] TIE_MULT     = 4'd8,
    parameter logic [7:0] MAX_BET      = 8'd50
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       bet_open,
    input  logic       bet_valid,
    input  logic [7:0] bet_amount,
    input  logic [1:0] bet_side,
    input  logic       settle_req,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    output logic [7:0] balance,
    output logic       bet_ack,
    output logic       bet_reject,
    output logic       settle_done,
    output logic       busy,
    output logic       broke
);

    state_t              r_state, w_state_next;
    logic [7:0]          r_balance, w_balance_next;
    logic [7:0]          r_escrow, w_escrow_next;
    logic [1:0]          r_side, w_side_next;
    logic [1:0]          r_lights, w_lights_next;
    logic [1:0]          r_phantom, w_phantom_next;
    logic                r_bet_ack, w_bet_ack_next;
    logic                r_bet_reject, w_bet_reject_next;
    logic                r_settle_done, w_settle_done_next;
    logic                r_broke;
    logic                w_bet_bad;
    logic [CREDIT_W-1:0] w_credit;
    logic [CREDIT_W:0]   w_sum;
    logic [7:0]          w_balance_sat;

    payout_calc #(
        .TIE_MULT (TIE_MULT)
    ) u_payout (
        .i_bet    (r_escrow),
        .i_side   (r_side),
        .i_lights (r_lights),
        .o_credit (w_credit)
    );

    assign w_bet_bad = (bet_amount == 8'd0) || (bet_amount > r_balance) ||
                       (bet_amount > MAX_BET) || (bet_side == SIDE_NONE);

    assign w_sum         = {1'b0, w_credit} + (CREDIT_W + 1)'(r_balance);
    assign w_balance_sat = (|w_sum[CREDIT_W:8]) ? 8'd255 : w_sum[7:0];

    always_comb begin
        w_state_next       = r_state;
        w_balance_next     = r_balance;
        w_escrow_next      = r_escrow;
        w_side_next        = r_side;
        w_lights_next      = r_lights;
        w_bet_ack_next     = 1'b0;
        w_bet_reject_next  = 1'b0;
        // A settle_req with nothing locked still owes a settle_done two
        // cycles later; this two-stage shift carries it without leaving IDLE.
        w_phantom_next     = {r_phantom[0], 1'b0};
        w_settle_done_next = r_phantom[1];

        case (r_state)
            ST_IDLE: begin
                if (settle_req)
                    w_phantom_next[0] = 1'b1;
                else if (bet_open)
                    w_state_next = ST_OPEN;
            end
            ST_OPEN: begin
                // A bet offer takes priority over a coincident settle_req.
                if (bet_valid) begin
                    if (w_bet_bad) begin
                        w_bet_reject_next = 1'b1;
                        w_state_next      = ST_IDLE;
                    end else begin
                        w_balance_next = r_balance - bet_amount;
                        w_escrow_next  = bet_amount;
                        w_side_next    = bet_side;
                        w_bet_ack_next = 1'b1;
                        w_state_next   = ST_LOCKED;
                    end
                end else if (settle_req) begin
                    w_phantom_next[0] = 1'b1;
                    w_state_next      = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (settle_req)
                    w_state_next = ST_SWAIT;
            end
            ST_SWAIT: begin
                w_lights_next = {player_win_light, dealer_win_light};
                w_state_next  = ST_SCALC;
            end
            ST_SCALC: begin
                w_balance_next     = w_balance_sat;
                w_escrow_next      = '0;
                w_side_next        = SIDE_NONE;
                w_settle_done_next = 1'b1;
                w_state_next       = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_balance     <= INIT_BALANCE;
            r_escrow      <= '0;
            r_side        <= SIDE_NONE;
            r_lights      <= '0;
            r_phantom     <= '0;
            r_bet_ack     <= 1'b0;
            r_bet_reject  <= 1'b0;
            r_settle_done <= 1'b0;
            r_broke       <= 1'b0;
        end else begin
            r_balance     <= w_balance_next;
            r_escrow      <= w_escrow_next;
            r_side        <= w_side_next;
            r_lights      <= w_lights_next;
            r_phantom     <= w_phantom_next;
            r_bet_ack     <= w_bet_ack_next;
            r_bet_reject  <= w_bet_reject_next;
            r_settle_done <= w_settle_done_next;
            r_broke       <= (w_balance_next == 8'd0) && (w_escrow_next == 8'd0);
        end
    end

    assign balance     = r_balance;
    assign bet_ack     = r_bet_ack;
    assign bet_reject  = r_bet_reject;
    assign settle_done = r_settle_done;
    assign busy        = (r_state == ST_SWAIT) || (r_state == ST_SCALC);
    assign broke       = r_broke;

endmodule
